margin_topk_select: RTL and testbench
=====================================

# margin_topk_select

Streaming selector for the margin-sampling datapath. It consumes one margin value per valid cycle, each tagged with the sample index from the index counter. Over a frame of `N_SAMPLES` samples it keeps the `K` smallest margins, then drains them in ascending order over a valid/ready interface. It sits at the receiving end of the index stream, after the margin compute stage and before the sample-selection writeback.

## Interface
Parameters:
- `N_SAMPLES`, default 512: number of samples per frame; must be ≥ `K`.
- `K`, default 4: number of lowest-margin samples reported.
- `DATA_WIDTH`, default 16: margin width, unsigned.
- `IDX_WIDTH`, default 16: sample index width; matches the index counter's `CNT_WIDTH`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; clears the table and begins a frame.
- `in_valid`  in  1  margin/index pair present this cycle.
- `in_margin`  in  DATA_WIDTH  unsigned margin.
- `in_index`  in  IDX_WIDTH  sample index from the index counter.
- `out_valid`  out  1  result entry presented.
- `out_ready`  in  1  downstream accepts the entry.
- `out_margin`  out  DATA_WIDTH  margin of the current rank.
- `out_index`  out  IDX_WIDTH  index of the current rank.
- `out_last`  out  1  current entry is rank K-1.
- `busy`  out  1  high in COLLECT or DRAIN.
- `done`  out  1  one-cycle pulse after the last drain handshake.

## Operation
- States:
  - IDLE: entered from reset, or from DRAIN after the final handshake.
  - COLLECT: entered on `start`.
  - DRAIN: entered after `N_SAMPLES` accepted samples.
- `start` in any state:
  - Invalidates all K table entries and zeroes the sample count.
  - Next state is COLLECT.
  - The `in_valid` sample in the same cycle is ignored.
- COLLECT behaviour:
  - Each cycle with `in_valid` high is one accepted sample; the count increments.
  - The table is held sorted ascending by margin, rank 0 being the smallest.
  - A new sample goes into the first rank that is either invalid or holds a margin strictly greater than it; lower ranks shift down by one and rank K-1 is discarded.
  - Ties: the earlier sample keeps the better rank.
  - A sample that beats no entry and finds no invalid slot is dropped.
- COLLECT → DRAIN when the accepted count reaches `N_SAMPLES`, i.e. on the cycle the last sample is written.
- `in_valid` is ignored in IDLE and DRAIN.
- DRAIN behaviour:
  - `out_valid` = 1, and `out_margin`/`out_index` show rank 0.
  - On each `out_valid && out_ready` the table shifts up one rank and the drain pointer increments.
  - `out_last` = 1 while presenting the K-th entry.
  - The handshake on that last entry sends the block to IDLE and pulses `done` in the next cycle.
- Outputs stay stable while `out_valid && !out_ready`.
- Arithmetic:
  - Comparisons are unsigned on `DATA_WIDTH` bits.
  - The sample count is `$clog2(N_SAMPLES+1)` bits, so it has no wrap inside a frame.
  - `in_index` is stored verbatim and is not checked for continuity.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State returns to IDLE and all entries become invalid.
  - `out_valid`, `out_last`, `busy`, `done` go to 0.
  - `out_margin` and `out_index` go to 0.
- Insertion latency: 1 cycle; the table is updated at the edge that samples `in_valid`.
- Full throughput: one sample per cycle, with no stall input upstream.
- Frame to drain: if the last sample is accepted at edge t, then `out_valid` = 1 and `busy` = 1 in the cycle after edge t.
- `done` is high for exactly the cycle after the last drain handshake; `busy` = 0 in that cycle.
- Drain rate: one entry per cycle when `out_ready` is held high, so K cycles minimum.
- `start` during DRAIN aborts the drain: `out_valid` = 0 from the next cycle and no `done` pulse is produced.
- Reset mid-frame gives the full reset values above; the in-progress frame is lost.

## Structure
- Shared package/header `margin_sampling_pkg` holds:
  - State encodings IDLE/COLLECT/DRAIN.
  - Shared `DATA_WIDTH`/`IDX_WIDTH` defaults used by the index counter and this block.
- One sub-module, `topk_slot`, instantiated K times. Each slot holds valid/margin/index and a "new sample beats me" compare. It chooses between hold, shift-from-above, or load-new, using its own compare result and the compare result of the slot above.
- The top level holds the FSM, the sample count and the drain pointer.

## Test plan
- K=4, N=8; margins 50,10,30,10,70,5,90,20 at indices 0..7, `out_ready`=1 → drain (5,5),(10,1),(10,3),(20,7); `out_last` on the 4th entry; `done` one cycle later.
- Same frame with `out_ready` low for 3 cycles at entry 2 → (10,3) held stable, no duplicate or lost entry.
- All 8 margins = 100 → indices 0,1,2,3 (tie rule).
- `start` reasserted after 5 samples, then a new 8-sample frame → results reflect only the new frame.
- `rst_n` low mid-DRAIN → all outputs 0 immediately, IDLE; `in_valid` pulses in IDLE change nothing and a later drain is unaffected.
- N=512, K=4, random margins → drain matches the reference model's sorted 4 lowest, with stable-order ties.

Source files
------------

// File: rtl/margin_sampling_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : margin_sampling_pkg                                             |
// | Function : Shared widths and FSM encodings for the margin-sampling path.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package margin_sampling_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 16;
    localparam int c_IDX_WIDTH_DEFAULT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } topk_state_t;

endpackage

`default_nettype wire

// File: rtl/margin_topk_select_slot.sv
// +----------------------------------------------------------------------------+
// | Module   : topk_slot                                                       |
// | Function : One rank of the sorted top-K table: hold, shift or load new.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module topk_slot #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  insert,
    input  logic                  shift_up,
    input  logic [DATA_WIDTH-1:0] new_margin,
    input  logic [IDX_WIDTH-1:0]  new_index,
    input  logic                  above_beats,
    input  logic                  above_valid,
    input  logic [DATA_WIDTH-1:0] above_margin,
    input  logic [IDX_WIDTH-1:0]  above_index,
    input  logic                  below_valid,
    input  logic [DATA_WIDTH-1:0] below_margin,
    input  logic [IDX_WIDTH-1:0]  below_index,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] margin,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  beats
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_margin;
    logic [IDX_WIDTH-1:0]  r_index;

    // Strict compare: an equal margin leaves the earlier sample in place.
    assign beats  = !r_valid || (new_margin < r_margin);
    assign valid  = r_valid;
    assign margin = r_margin;
    assign index  = r_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_margin <= '0;
            r_index  <= '0;
        end else if (clear) begin
            r_valid  <= 1'b0;
        end else if (insert && beats) begin
            // If the slot above is also beaten, the new sample lands higher up.
            if (above_beats) begin
                r_valid  <= above_valid;
                r_margin <= above_margin;
                r_index  <= above_index;
            end else begin
                r_valid  <= 1'b1;
                r_margin <= new_margin;
                r_index  <= new_index;
            end
        end else if (shift_up) begin
            r_valid  <= below_valid;
            r_margin <= below_margin;
            r_index  <= below_index;
        end
    end

endmodule

`default_nettype wire

// File: rtl/margin_topk_select.sv
// +----------------------------------------------------------------------------+
// | Module   : margin_topk_select                                              |
// | Function : Keeps the K smallest margins of a frame, drains them ascending. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module margin_topk_select
    import margin_sampling_pkg::*;
#(
    parameter int N_SAMPLES  = 512,
    parameter int K          = 4,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int IDX_WIDTH  = c_IDX_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_margin,
    input  logic [IDX_WIDTH-1:0]  in_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_margin,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_CNT_W = $clog2(N_SAMPLES + 1);
    localparam int c_PTR_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N_SAMPLES - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(K - 1);

    topk_state_t          r_state;
    topk_state_t          w_state_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_ptr;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_hs;
    logic                 w_last_hs;

    logic                  w_valid  [K];
    logic [DATA_WIDTH-1:0] w_margin [K];
    logic [IDX_WIDTH-1:0]  w_index  [K];
    logic                  w_beats  [K];

    assign w_accept    = (r_state == ST_COLLECT) && in_valid && !start;
    assign w_frame_end = w_accept && (r_count == c_CNT_LAST);
    assign w_hs        = (r_state == ST_DRAIN) && out_ready && !start;
    assign w_last_hs   = w_hs && (r_ptr == c_PTR_LAST);

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic                  w_ab;
        logic                  w_av;
        logic [DATA_WIDTH-1:0] w_am;
        logic [IDX_WIDTH-1:0]  w_ai;
        logic                  w_bv;
        logic [DATA_WIDTH-1:0] w_bm;
        logic [IDX_WIDTH-1:0]  w_bi;

        if (i == 0) begin : g_head
            assign w_ab = 1'b0;
            assign w_av = 1'b0;
            assign w_am = '0;
            assign w_ai = '0;
        end else begin : g_above
            assign w_ab = w_beats[i-1];
            assign w_av = w_valid[i-1];
            assign w_am = w_margin[i-1];
            assign w_ai = w_index[i-1];
        end

        // The tail rank empties as the drain shifts entries toward rank 0.
        if (i == K - 1) begin : g_tail
            assign w_bv = 1'b0;
            assign w_bm = '0;
            assign w_bi = '0;
        end else begin : g_below
            assign w_bv = w_valid[i+1];
            assign w_bm = w_margin[i+1];
            assign w_bi = w_index[i+1];
        end

        topk_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .IDX_WIDTH  (IDX_WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (start),
            .insert       (w_accept),
            .shift_up     (w_hs),
            .new_margin   (in_margin),
            .new_index    (in_index),
            .above_beats  (w_ab),
            .above_valid  (w_av),
            .above_margin (w_am),
            .above_index  (w_ai),
            .below_valid  (w_bv),
            .below_margin (w_bm),
            .below_index  (w_bi),
            .valid        (w_valid[i]),
            .margin       (w_margin[i]),
            .index        (w_index[i]),
            .beats        (w_beats[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_COLLECT: if (w_frame_end) w_state_next = ST_DRAIN;
                ST_DRAIN:   if (w_last_hs)   w_state_next = ST_IDLE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (start) begin
                r_count <= '0;
                r_ptr   <= '0;
            end else begin
                if (w_accept) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_frame_end || w_last_hs) begin
                    r_ptr <= '0;
                end else if (w_hs) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    assign out_valid  = (r_state == ST_DRAIN);
    assign out_last   = (r_state == ST_DRAIN) && (r_ptr == c_PTR_LAST);
    assign out_margin = w_margin[0];
    assign out_index  = w_index[0];
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_margin_topk_select.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_margin_topk_select                                           |
// | Function : Scoreboard bench for margin_topk_select (N=8 and N=512, K=4).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_margin_topk_select;

    localparam int K   = 4;
    localparam int NS  = 8;
    localparam int NB  = 512;

    typedef struct {
        logic [15:0] m;
        logic [15:0] i;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s_start = 0, s_in_valid = 0, s_ready = 0;
    logic [15:0] s_margin = 0, s_index = 0;
    logic        s_out_valid, s_out_last, s_busy, s_done;
    logic [15:0] s_out_margin, s_out_index;

    logic        b_start = 0, b_in_valid = 0, b_ready = 0;
    logic [15:0] b_margin = 0, b_index = 0;
    logic        b_out_valid, b_out_last, b_busy, b_done;
    logic [15:0] b_out_margin, b_out_index;

    exp_t exp_s[$];
    exp_t exp_b[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_s = 0;
    bit   s_done_exp = 0;
    bit   b_done_exp = 0;
    int   frame_m[NB];
    int   frame_i[NB];

    always #5 clk = ~clk;

    margin_topk_select #(.N_SAMPLES(NS), .K(K), .DATA_WIDTH(16), .IDX_WIDTH(16)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_margin(s_margin), .in_index(s_index), .out_valid(s_out_valid),
        .out_ready(s_ready), .out_margin(s_out_margin), .out_index(s_out_index),
        .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    margin_topk_select #(.N_SAMPLES(NB), .K(K), .DATA_WIDTH(16), .IDX_WIDTH(16)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
        .in_margin(b_margin), .in_index(b_index), .out_valid(b_out_valid),
        .out_ready(b_ready), .out_margin(b_out_margin), .out_index(b_out_index),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: repeatedly pick the smallest unused margin, earliest index on ties.
    task automatic model_push(input int n, input bit big);
        bit used[NB];
        exp_t e;
        for (int j = 0; j < NB; j++) used[j] = 0;
        for (int r = 0; r < K; r++) begin
            int best = -1;
            for (int j = 0; j < n; j++)
                if (!used[j] && (best < 0 || frame_m[j] < frame_m[best])) best = j;
            used[best] = 1;
            e.m = 16'(frame_m[best]);
            e.i = 16'(frame_i[best]);
            e.last = (r == K - 1);
            if (big) exp_b.push_back(e);
            else     exp_s.push_back(e);
        end
    endtask

    task automatic start_s();
        s_start = 1; @(posedge clk); #1; s_start = 0;
    endtask

    task automatic send_s(input int n);
        for (int j = 0; j < n; j++) begin
            s_in_valid = 1; s_margin = 16'(frame_m[j]); s_index = 16'(frame_i[j]);
            @(posedge clk); #1;
        end
        s_in_valid = 0;
    endtask

    task automatic load(input int m0, m1, m2, m3, m4, m5, m6, m7, input int base);
        frame_m[0] = m0; frame_m[1] = m1; frame_m[2] = m2; frame_m[3] = m3;
        frame_m[4] = m4; frame_m[5] = m5; frame_m[6] = m6; frame_m[7] = m7;
        for (int j = 0; j < NS; j++) frame_i[j] = base + j;
    endtask

    task automatic wait_drain_s(input string name);
        int c = 0;
        while (exp_s.size() != 0 && c < 100) begin @(posedge clk); #1; c++; end
        if (c >= 100) chk(0, name, exp_s.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: sample at negedge, compare each handshake with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (s_done_exp) begin
                chk(s_done === 1'b1, "s_done_pulse", int'(s_done), 1);
                chk(s_busy === 1'b0, "s_busy_at_done", int'(s_busy), 0);
                s_done_exp = 0;
            end else if (s_done) begin
                chk(0, "s_unexpected_done", 1, 0);
            end
            if (s_out_valid && s_ready) begin
                if (exp_s.size() == 0) begin
                    chk(0, "s_unexpected_out", int'(s_out_index), -1);
                end else begin
                    e = exp_s.pop_front();
                    chk(s_out_margin === e.m, "s_margin", int'(s_out_margin), int'(e.m));
                    chk(s_out_index === e.i, "s_index", int'(s_out_index), int'(e.i));
                    chk(s_out_last === e.last, "s_last", int'(s_out_last), int'(e.last));
                    if (e.last) s_done_exp = 1;
                    hs_s++;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (b_done_exp) begin
                chk(b_done === 1'b1, "b_done_pulse", int'(b_done), 1);
                b_done_exp = 0;
            end
            if (b_out_valid && b_ready) begin
                if (exp_b.size() == 0) begin
                    chk(0, "b_unexpected_out", int'(b_out_index), -1);
                end else begin
                    e = exp_b.pop_front();
                    chk(b_out_margin === e.m, "b_margin", int'(b_out_margin), int'(e.m));
                    chk(b_out_index === e.i, "b_index", int'(b_out_index), int'(e.i));
                    chk(b_out_last === e.last, "b_last", int'(b_out_last), int'(e.last));
                    if (e.last) b_done_exp = 1;
                end
            end
        end
    end

    initial begin
        int c;
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk(s_out_valid === 0, "rst_out_valid", int'(s_out_valid), 0);
        chk(s_out_last === 0, "rst_out_last", int'(s_out_last), 0);
        chk(s_busy === 0, "rst_busy", int'(s_busy), 0);
        chk(s_done === 0, "rst_done", int'(s_done), 0);
        chk(s_out_margin === 0, "rst_out_margin", int'(s_out_margin), 0);
        chk(s_out_index === 0, "rst_out_index", int'(s_out_index), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Basic frame: expect (5,5),(10,1),(10,3),(20,7).
        s_ready = 1;
        load(50, 10, 30, 10, 70, 5, 90, 20, 0);
        model_push(NS, 0);
        start_s();
        chk(s_busy === 1, "collect_busy", int'(s_busy), 1);
        send_s(NS);
        chk(s_out_valid === 1, "drain_valid_latency", int'(s_out_valid), 1);
        chk(s_busy === 1, "drain_busy", int'(s_busy), 1);
        wait_drain_s("basic_timeout");

        // Same frame, downstream stalls three cycles on entry 2.
        model_push(NS, 0);
        base = hs_s;
        start_s();
        send_s(NS);
        c = 0;
        while (hs_s < base + 2 && c < 50) begin @(posedge clk); #1; c++; end
        if (c >= 50) chk(0, "stall_reach_timeout", hs_s - base, 2);
        s_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk(s_out_valid === 1, "stall_valid", int'(s_out_valid), 1);
            chk(s_out_margin === 10, "stall_margin", int'(s_out_margin), 10);
            chk(s_out_index === 3, "stall_index", int'(s_out_index), 3);
            @(posedge clk); #1;
        end
        s_ready = 1;
        wait_drain_s("stall_timeout");

        // All margins equal: earliest indices win.
        load(100, 100, 100, 100, 100, 100, 100, 100, 0);
        model_push(NS, 0);
        start_s();
        send_s(NS);
        wait_drain_s("tie_timeout");

        // Restart after 5 samples; only the second frame counts.
        load(1, 2, 3, 4, 5, 6, 7, 8, 0);
        start_s();
        send_s(5);
        load(40, 35, 60, 35, 80, 45, 33, 90, 100);
        model_push(NS, 0);
        start_s();
        send_s(NS);
        wait_drain_s("restart_timeout");

        // Reset in the middle of a stalled drain.
        s_ready = 0;
        load(9, 8, 7, 6, 5, 4, 3, 2, 20);
        start_s();
        send_s(NS);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk(s_out_valid === 0, "midrst_out_valid", int'(s_out_valid), 0);
        chk(s_busy === 0, "midrst_busy", int'(s_busy), 0);
        chk(s_out_last === 0, "midrst_out_last", int'(s_out_last), 0);
        chk(s_out_margin === 0, "midrst_out_margin", int'(s_out_margin), 0);
        chk(s_out_index === 0, "midrst_out_index", int'(s_out_index), 0);
        @(posedge clk); #1;
        rst_n = 1;
        s_ready = 1;
        repeat (3) begin
            s_in_valid = 1; s_margin = 0; s_index = 16'hBEEF;
            @(posedge clk); #1;
            chk(s_busy === 0, "idle_ignore_busy", int'(s_busy), 0);
            chk(s_out_valid === 0, "idle_ignore_valid", int'(s_out_valid), 0);
        end
        s_in_valid = 0;
        load(50, 10, 30, 10, 70, 5, 90, 20, 0);
        model_push(NS, 0);
        start_s();
        send_s(NS);
        wait_drain_s("post_reset_timeout");

        // A few small frames with narrow margins to provoke ties.
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < NS; j++) begin
                frame_m[j] = int'($urandom_range(0, 7));
                frame_i[j] = j * 3 + 1 + f * 40;
            end
            model_push(NS, 0);
            start_s();
            send_s(NS);
            wait_drain_s("rand_small_timeout");
        end

        // Full-size frame on the N=512 instance.
        for (int j = 0; j < NB; j++) begin
            frame_m[j] = int'($urandom_range(0, 255));
            frame_i[j] = j;
        end
        model_push(NB, 1);
        b_ready = 1;
        b_start = 1; @(posedge clk); #1; b_start = 0;
        for (int j = 0; j < NB; j++) begin
            b_in_valid = 1; b_margin = 16'(frame_m[j]); b_index = 16'(frame_i[j]);
            @(posedge clk); #1;
        end
        b_in_valid = 0;
        c = 0;
        while (exp_b.size() != 0 && c < 100) begin @(posedge clk); #1; c++; end
        if (c >= 100) chk(0, "big_timeout", exp_b.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        chk(exp_s.size() == 0, "s_queue_empty", exp_s.size(), 0);
        chk(exp_b.size() == 0, "b_queue_empty", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
